imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Parameters
REQ-001 SHALL have parameter WIDTH, default 32, giving the address and instruction width.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, giving the instruction-memory depth in words.
REQ-003 SHALL have parameter TIMEOUT, default 1000, giving the maximum cycles allowed between accepted bytes.

Interface
REQ-004 SHALL provide the ports below; one clock, synchronous active-high reset:
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; requests a new program load
- byte_valid  in  1  byte source has data
- byte_data  in  8  byte from the source (UART RX path)
- byte_ready  out  1  loader accepts a byte this cycle
- fetch_addr  in  WIDTH  core instruction-fetch byte address
- imem_addr  out  WIDTH  byte address driven to the instruction memory
- imem_we  out  1  instruction-memory write strobe
- imem_wdata  out  WIDTH  instruction word to write
- core_hold  out  1  holds the core in stall/reset while high
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when a load completes
- error  out  1  sticky timeout flag

Function
REQ-005 SHALL implement the states IDLE, HDR, DATA, WR, FIN and ERR.
REQ-006 Byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 only in HDR and DATA.
REQ-007 IDLE, FIN or ERR with start=1 -> HDR; start in HDR, DATA or WR SHALL be ignored.
REQ-008 HDR: the accepted byte is the word count N; 0 SHALL mean MEM_DEPTH; counts above MEM_DEPTH SHALL be clamped to MEM_DEPTH; then -> DATA with byte_idx=0 and word_idx=0.
REQ-009 DATA: bytes SHALL assemble little-endian (byte_idx 0 -> bits 7:0 ... byte_idx 3 -> bits 31:24); the 4th accepted byte -> WR on the next cycle.
REQ-010 WR: exactly one cycle with imem_we=1, imem_addr=word_idx<<2 and imem_wdata=the assembled word; then word_idx increments; the last word (word_idx==N-1) -> FIN, otherwise -> DATA.
REQ-011 FIN: done=1 for exactly one cycle, then -> IDLE.
REQ-012 imem_addr SHALL equal fetch_addr whenever imem_we=0; the write address SHALL take priority only during WR.
REQ-013 core_hold=1 in HDR, DATA, WR and ERR; 0 in IDLE and FIN. busy=1 in HDR, DATA and WR.
REQ-014 The timeout counter SHALL clear on entry to HDR and on every accepted byte, and count each cycle in HDR or DATA without an accepted byte; reaching TIMEOUT -> ERR.
REQ-015 ERR: error=1 and core_hold=1 until start; start from ERR SHALL clear error and enter HDR.
REQ-016 word_idx SHALL be wide enough for MEM_DEPTH without wrap; no write SHALL occur at address >= MEM_DEPTH*4.
REQ-017 imem_wdata SHALL be 0 whenever imem_we=0.

Reset
REQ-018 rst=1 SHALL force IDLE and clear byte_idx, word_idx, N, the timeout counter and the assembly register on the next edge.
REQ-019 After reset: byte_ready=0, imem_we=0, imem_wdata=0, core_hold=0, busy=0, done=0, error=0, imem_addr=fetch_addr.
REQ-020 Reset mid-load SHALL abort with no further writes; words already written remain in memory.

Verification
REQ-021 start; bytes 01,93,00,a0,01 -> one WR cycle, imem_addr=0, imem_wdata=01a00093; done pulse; core_hold falls in FIN.
REQ-022 Count byte 00 followed by 1024 bytes -> 256 WR cycles with addresses 0x000..0x3fc; no write at 0x400; done once.
REQ-023 Count 02, then 3 bytes and byte_valid held low for TIMEOUT cycles -> ERR, error=1, core_hold=1, no WR; next start -> HDR with error=0.
REQ-024 start pulsed during DATA, with gaps of 0-5 cycles in byte_valid -> load unaffected, correct words, byte_ready low in WR.
REQ-025 rst asserted in DATA after 2 of 3 words -> next cycle IDLE, all outputs at reset values, no 3rd write, imem_addr follows fetch_addr.
REQ-026 IDLE with fetch_addr toggling 0x0, 0x4, 0x50 -> imem_addr matches each cycle, imem_we=0.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader: streams a counted program of little-endian words from a byte  |
// | source into instruction memory while holding the core.  Revision: 1.0      |
// +----------------------------------------------------------------------------+
module imem_loader #(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 256,
  parameter int TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic [WIDTH-1:0] fetch_addr,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_we,
  output logic [WIDTH-1:0] imem_wdata,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int CW = $clog2(MEM_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [CW-1:0]    word_idx_q, word_idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             accept;

  assign byte_ready = (state_q == HDR) || (state_q == DATA);
  assign accept     = byte_valid && byte_ready;
  assign imem_we    = (state_q == WR);
  assign imem_addr  = imem_we ? (WIDTH'(word_idx_q) << 2) : fetch_addr;
  assign imem_wdata = imem_we ? word_q : '0;
  assign core_hold  = (state_q == HDR) || (state_q == DATA) || (state_q == WR) || (state_q == ERR);
  assign busy       = (state_q == HDR) || (state_q == DATA) || (state_q == WR);
  assign done       = (state_q == FIN);
  assign error      = (state_q == ERR);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    word_d     = word_q;
    case (state_q)
      IDLE, FIN, ERR: begin
        if (start) begin
          state_d    = HDR;
          byte_idx_d = 2'd0;
          word_idx_d = '0;
          tmo_d      = '0;
          word_d     = '0;
        end else if (state_q == FIN) begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (accept) begin
          // A zero count means a full memory; larger counts are clamped to it
          if (byte_data == 8'd0 || 32'(byte_data) > MEM_DEPTH) begin
            cnt_d = CW'(MEM_DEPTH);
          end else begin
            cnt_d = CW'(byte_data);
          end
          state_d    = DATA;
          byte_idx_d = 2'd0;
          word_idx_d = '0;
          tmo_d      = '0;
        end else begin
          if (tmo_q == TW'(TIMEOUT - 1)) state_d = ERR;
          tmo_d = tmo_q + TW'(1);
        end
      end
      DATA: begin
        if (accept) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          tmo_d      = '0;
          if (byte_idx_q == 2'd3) state_d = WR;
        end else begin
          if (tmo_q == TW'(TIMEOUT - 1)) state_d = ERR;
          tmo_d = tmo_q + TW'(1);
        end
      end
      WR: begin
        word_idx_d = word_idx_q + CW'(1);
        state_d    = (word_idx_q == cnt_q - CW'(1)) ? FIN : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= 2'd0;
      word_idx_q <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      word_q     <= word_d;
    end
  end

endmodule
`default_nettype wire
